pulp_periph_demux: RTL and testbench
====================================

Name: pulp_periph_demux

Overview:
- Parametrised successor of the fixed cluster-peripheral address map: routes one core-side data request stream to NumSlv peripheral ports through a configurable slot-to-port table.
- Tracks up to MaxTrans outstanding transactions and returns responses in order.
- Answers unmapped slots from an internal error responder.
- Sits between the peripheral interconnect master plug and the cluster peripherals (EOC, timer, event unit, DMA, HMR, ...).

Parameters:
- NumSlv, 11, number of peripheral ports (1..32).
- NumSlots, 16, number of address slots in the peripheral region (power of two).
- SlotBits, 10, log2 of slot size in bytes (1 KiB).
- RegionBase, 32'h1020_0000, peripheral region base, aligned to NumSlots<<SlotBits.
- SlotMap, packed array of NumSlots x 8 bits, target port per slot; 8'hFF means unmapped. Default: slot s -> s for s in 0..2 and 4..10; slot 3 -> 2 (event unit spans two slots); slots 11..15 -> FF.
- MaxTrans, 4, outstanding transaction depth (>=1).
- ErrData, 32'hBADA_CCE5, read data returned on error.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- req_i, in, 1, master request.
- add_i, in, 32, byte address.
- we_i, in, 1, 1 = write.
- wdata_i, in, 32, write data.
- be_i, in, 4, byte enables.
- gnt_o, out, 1, request accepted this cycle.
- r_valid_o, out, 1, response valid.
- r_rdata_o, out, 32, response data.
- r_opc_o, out, 1, 1 = error response.
- slv_req_o, out, NumSlv, per-port request.
- slv_add_o / slv_we_o / slv_wdata_o / slv_be_o, out, 32/1/32/4, broadcast to all ports.
- slv_gnt_i, in, NumSlv, per-port grant.
- slv_r_valid_i, in, NumSlv, per-port response valid.
- slv_r_rdata_i, in, NumSlv x 32, per-port read data.
- spurious_o, out, 1, sticky flag: unexpected slave r_valid seen.

Behaviour:
- Decode (combinational):
  - in_region = add_i[31:log2(NumSlots)+SlotBits] equals the same bits of RegionBase.
  - slot = add_i[SlotBits +: log2(NumSlots)].
  - tgt = SlotMap[slot].
  - err = !in_region | tgt==FF | tgt>=NumSlv.
- Outstanding FIFO: MaxTrans entries of {tgt, err}, registered, with count register. last_tgt/last_err hold the most recently pushed entry.
- can_issue = !full & (empty | ({last_err,last_tgt}=={err,tgt})). A new request to a different target stalls until all outstanding transactions drain, which guarantees in-order responses.
- Normal path:
  - slv_req_o[tgt] = req_i & !err & can_issue; all other bits 0.
  - gnt_o = slv_gnt_i[tgt] & slv_req_o[tgt].
  - Push on gnt_o. Request path adds zero latency.
- Error path: gnt_o = req_i & can_issue, no slave request, push {err=1}.
- Response:
  - Head entry err=1: r_valid_o=1, r_rdata_o=ErrData, r_opc_o=1, pop. An error response is therefore issued no earlier than 1 cycle after grant.
  - Head entry err=0: r_valid_o = slv_r_valid_i[head.tgt], r_rdata_o = slv_r_rdata_i[head.tgt], r_opc_o=0, pop on r_valid_o. Zero added latency.
- Simultaneous push and pop in one cycle: count unchanged; the full check uses the pre-pop count (conservative).
- Any slv_r_valid_i[i] asserted while FIFO empty, or for i != head.tgt (non-err head), sets spurious_o and is dropped. spurious_o clears only on reset.
- Slave requirements: hold responses in order and give r_valid ≥1 cycle after gnt.
- Reset (rst_i=1 at posedge): FIFO emptied, count=0, spurious_o=0. Combinationally this forces gnt_o=0, r_valid_o=0, r_rdata_o=0, r_opc_o=0, slv_req_o=0. Transactions in flight at reset are abandoned; their late responses set spurious_o.
- Master requirement: hold request fields stable while req_i=1 & gnt_o=0.

Decomposition:
- Package pulp_periph_demux_pkg: slot-map entry type (8 bit), UNMAPPED=8'hFF constant, default SlotMap constant derived from the SPER_* IDs, FIFO entry struct {tgt, err}.
- Reuse core_data_req_t/core_data_rsp_t for the master-side bundle in the wrapper.
- One sub-module: pulp_periph_demux_fifo (registered in-order tracker, parametrised depth/width, push/pop/full/empty/head/last).

Test Plan:
- Read 0x1020_0404 (slot 1), timer gnt same cycle, r_valid 2 cycles later with 0x1234 -> slv_req_o=bit1, gnt_o=1, r_rdata_o=0x1234, r_opc_o=0.
- Accesses to 0x1020_0C00 (slot 3) and 0x1020_0800 (slot 2) -> both route to port 2.
- Write to 0x1020_3000 (slot 12, unmapped) -> gnt_o same cycle, no slv_req_o, next cycle r_valid_o=1, r_opc_o=1, r_rdata_o=0xBADACCE5. An address outside the region, 0x1000_0000, gives the same result.
- 5 back-to-back reads to port 6, slave grants every cycle and delays all responses by 8 cycles -> 4 grants, 5th stalled until the first response pops; responses returned in order.
- Read port 1 outstanding, then request to port 7 -> port 7 slv_req_o=0 until port 1 responds; port 7 then granted.
- rst_i asserted with 2 outstanding transactions, then slave responds -> all outputs 0 during reset, spurious_o=1 after the late r_valid, no r_valid_o.

Source files
------------

// File: rtl/pulp_periph_demux_pkg.sv
// Shared types and the default cluster-peripheral slot map for the peripheral demux.
package pulp_periph_demux_pkg;

   localparam int unsigned AddrW       = 32;
   localparam int unsigned DataW       = 32;
   localparam int unsigned BeW         = 4;
   localparam int unsigned DefNumSlots = 16;

   typedef logic [7:0] slot_tgt_t;

   localparam slot_tgt_t UNMAPPED = 8'hFF;

   localparam slot_tgt_t SPER_EOC_ID         = 8'd0;
   localparam slot_tgt_t SPER_TIMER_ID       = 8'd1;
   localparam slot_tgt_t SPER_EVENT_U_ID     = 8'd2;
   localparam slot_tgt_t SPER_HWPE_ID        = 8'd4;
   localparam slot_tgt_t SPER_ICACHE_CTRL_ID = 8'd5;
   localparam slot_tgt_t SPER_DMA_CL_ID      = 8'd6;
   localparam slot_tgt_t SPER_DMA_FC_ID      = 8'd7;
   localparam slot_tgt_t SPER_HMR_ID         = 8'd8;
   localparam slot_tgt_t SPER_EXT_PER_ID     = 8'd9;
   localparam slot_tgt_t SPER_DEBUG_ID       = 8'd10;

   // Slot 15 first; the event unit occupies slots 2 and 3.
   localparam logic [DefNumSlots-1:0][7:0] DefaultSlotMap = {
      UNMAPPED, UNMAPPED, UNMAPPED, UNMAPPED, UNMAPPED,
      SPER_DEBUG_ID, SPER_EXT_PER_ID, SPER_HMR_ID, SPER_DMA_FC_ID,
      SPER_DMA_CL_ID, SPER_ICACHE_CTRL_ID, SPER_HWPE_ID,
      SPER_EVENT_U_ID, SPER_EVENT_U_ID, SPER_TIMER_ID, SPER_EOC_ID
   };

   typedef struct packed {
      logic      err;
      slot_tgt_t tgt;
   } fifo_entry_t;

   typedef struct packed {
      logic             req;
      logic [AddrW-1:0] add;
      logic             we;
      logic [DataW-1:0] wdata;
      logic [BeW-1:0]   be;
   } core_data_req_t;

   typedef struct packed {
      logic             gnt;
      logic             r_valid;
      logic [DataW-1:0] r_rdata;
      logic             r_opc;
   } core_data_rsp_t;

endpackage

// File: rtl/pulp_periph_demux_if.sv
// Core-side data request/response bundle between the peripheral interconnect and the demux.
interface pulp_periph_demux_if;
   import pulp_periph_demux_pkg::*;

   core_data_req_t req;
   core_data_rsp_t rsp;

   modport master (output req, input rsp);
   modport slave  (input req, output rsp);
endinterface

// File: rtl/pulp_periph_demux_fifo.sv
// In-order tracker of outstanding transactions; also remembers the most recent push.
module pulp_periph_demux_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 9
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [Width-1:0] head_o,
   output logic [Width-1:0] last_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [Width-1:0] last_q, last_d;
   logic             push_ok, pop_ok;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign head_o  = mem_q[rd_ptr_q];
   assign last_o  = last_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      if (push_ok) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
         last_d   = data_i;
      end
      if (pop_ok) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         last_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
      end
   end

   // Payload storage needs no reset: entries are only read while counted.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/pulp_periph_demux.sv
// Routes one core data stream to NumSlv peripherals via a slot map, in-order responses,
// with an internal error responder for unmapped or out-of-region accesses.
module pulp_periph_demux
   import pulp_periph_demux_pkg::*;
#(
   parameter int unsigned              NumSlv     = 11,
   parameter int unsigned              NumSlots   = DefNumSlots,
   parameter int unsigned              SlotBits   = 10,
   parameter logic [31:0]              RegionBase = 32'h1020_0000,
   parameter logic [NumSlots-1:0][7:0] SlotMap    = DefaultSlotMap,
   parameter int unsigned              MaxTrans   = 4,
   parameter logic [31:0]              ErrData    = 32'hBADA_CCE5
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   pulp_periph_demux_if.slave      mst,
   output logic [NumSlv-1:0]       slv_req_o,
   output logic [31:0]             slv_add_o,
   output logic                    slv_we_o,
   output logic [31:0]             slv_wdata_o,
   output logic [3:0]              slv_be_o,
   input  logic [NumSlv-1:0]       slv_gnt_i,
   input  logic [NumSlv-1:0]       slv_r_valid_i,
   input  logic [NumSlv-1:0][31:0] slv_r_rdata_i,
   output logic                    spurious_o
);

   localparam int unsigned SlotIdxW = $clog2(NumSlots);
   localparam int unsigned RegLsb   = SlotIdxW + SlotBits;
   localparam int unsigned EntryW   = $bits(fifo_entry_t);

   logic [SlotIdxW-1:0] slot;
   slot_tgt_t           tgt;
   logic                in_region, err, can_issue, gnt, pop;
   logic                full, empty;
   fifo_entry_t         cur, head, last;
   logic [NumSlv-1:0]   tgt_oh, head_oh, exp_mask, unexpected;
   core_data_rsp_t      mst_rsp;
   logic                spurious_q, spurious_d;

   // Address decode
   assign in_region = (mst.req.add[31:RegLsb] == RegionBase[31:RegLsb]);
   assign slot      = mst.req.add[SlotBits +: SlotIdxW];
   assign tgt       = SlotMap[slot];
   assign err       = ~in_region | (tgt == UNMAPPED) | (tgt >= 8'(NumSlv));
   assign cur       = '{err: err, tgt: tgt};

   // Only one target may be outstanding at a time, which keeps responses ordered.
   assign can_issue = ~full & (empty | (last == cur));

   always_comb begin
      tgt_oh  = '0;
      head_oh = '0;
      for (int unsigned i = 0; i < NumSlv; i++) begin
         tgt_oh[i]  = (tgt == 8'(i));
         head_oh[i] = (head.tgt == 8'(i));
      end
   end

   assign slv_req_o   = (~rst_i & mst.req.req & ~err & can_issue) ? tgt_oh : '0;
   assign gnt         = ~rst_i & mst.req.req & can_issue & (err | (|(tgt_oh & slv_gnt_i)));
   assign slv_add_o   = mst.req.add;
   assign slv_we_o    = mst.req.we;
   assign slv_wdata_o = mst.req.wdata;
   assign slv_be_o    = mst.req.be;

   pulp_periph_demux_fifo #(
      .Depth (MaxTrans),
      .Width (EntryW)
   ) i_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (gnt),
      .data_i  (cur),
      .pop_i   (pop),
      .full_o  (full),
      .empty_o (empty),
      .head_o  (head),
      .last_o  (last)
   );

   // Response: error entries answer locally, others pass the head target through.
   always_comb begin
      mst_rsp  = '0;
      exp_mask = '0;
      if (!empty) begin
         if (head.err) begin
            mst_rsp.r_valid = 1'b1;
            mst_rsp.r_rdata = ErrData;
            mst_rsp.r_opc   = 1'b1;
         end else begin
            exp_mask        = head_oh;
            mst_rsp.r_valid = |(slv_r_valid_i & head_oh);
            for (int unsigned i = 0; i < NumSlv; i++) begin
               if (head_oh[i]) begin
                  mst_rsp.r_rdata = slv_r_rdata_i[i];
               end
            end
         end
      end
      mst_rsp.gnt = gnt;
      if (rst_i) begin
         mst_rsp = '0;
      end
   end

   assign pop     = mst_rsp.r_valid;
   assign mst.rsp = mst_rsp;

   // Any slave response not matching the head target is dropped and flagged.
   assign unexpected = slv_r_valid_i & ~exp_mask;
   assign spurious_d = spurious_q | (|unexpected);
   assign spurious_o = spurious_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         spurious_q <= 1'b0;
      end else begin
         spurious_q <= spurious_d;
      end
   end

endmodule

// File: tb/tb_pulp_periph_demux.sv
// Randomized and directed bench for pulp_periph_demux against a queue-based
// model of the slot map, in-order tracker and per-port slaves.
module tb_pulp_periph_demux;

   localparam int NSLV = 11;
   localparam int MAXT = 4;
   localparam logic [31:0] ERRD = 32'hBADA_CCE5;

   typedef struct { int tgt; bit err; } ent_t;
   typedef struct { int port; int unsigned rdy; logic [31:0] data; } sresp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NSLV-1:0]       slv_req;
   logic [31:0]           slv_add, slv_wdata;
   logic                  slv_we;
   logic [3:0]            slv_be;
   logic [NSLV-1:0]       slv_gnt = '0;
   logic [NSLV-1:0]       slv_rv = '0;
   logic [NSLV-1:0][31:0] slv_rd = '0;
   logic                  spurious;

   pulp_periph_demux_if mst_if ();

   pulp_periph_demux dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .mst           (mst_if),
      .slv_req_o     (slv_req),
      .slv_add_o     (slv_add),
      .slv_we_o      (slv_we),
      .slv_wdata_o   (slv_wdata),
      .slv_be_o      (slv_be),
      .slv_gnt_i     (slv_gnt),
      .slv_r_valid_i (slv_rv),
      .slv_r_rdata_i (slv_rd),
      .spurious_o    (spurious)
   );

   always #5 clk = ~clk;

   int map [16] = '{0, 1, 2, 2, 4, 5, 6, 7, 8, 9, 10, 255, 255, 255, 255, 255};

   int vecs = 0;
   int errs = 0;
   int unsigned cyc = 0;
   ent_t   oq[$];
   sresp_t slave_q[$];
   bit sp_exp = 1'b0;

   // Stimulus knobs
   bit          m_rst = 1'b1, m_req = 1'b0, m_we = 1'b0;
   logic [31:0] m_add = '0, m_wdata = '0;
   logic [3:0]  m_be = '0;
   int          gnt_pct = 100, lat_min = 1, lat_max = 1;
   bit          force_en = 1'b0;
   logic [31:0] force_data = '0;

   // Last-step observations
   bit          p_gnt, o_gnt, o_rv, o_opc, o_sp;
   logic [31:0] o_sreq, o_rd;
   int unsigned step_cyc;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic void decode(input logic [31:0] a, output int tgt, output bit err);
      bit inr;
      int slot;
      inr  = ((a / 32'h4000) == (32'h1020_0000 / 32'h4000));
      slot = int'((a / 32'd1024) % 32'd16);
      tgt  = map[slot];
      err  = !inr || (tgt == 255) || (tgt >= NSLV);
   endfunction

   task automatic step();
      int tgt;
      bit err, can, exp_gnt, exp_rv, exp_opc;
      logic [31:0] exp_rd;
      logic [NSLV-1:0] seen, exp_sreq, exp_mask, unexp;
      @(negedge clk);
      rst = m_rst;
      for (int p = 0; p < NSLV; p++) begin
         slv_gnt[p] = ($urandom_range(99) < gnt_pct);
         slv_rd[p]  = '0;
      end
      slv_rv = '0;
      seen   = '0;
      for (int k = 0; k < slave_q.size(); k++) begin
         int p;
         p = slave_q[k].port;
         if (!seen[p]) begin
            seen[p] = 1'b1;
            if (slave_q[k].rdy <= cyc) begin
               slv_rv[p] = 1'b1;
               slv_rd[p] = slave_q[k].data;
            end
         end
      end
      mst_if.req.req   = m_req;
      mst_if.req.add   = m_add;
      mst_if.req.we    = m_we;
      mst_if.req.wdata = m_wdata;
      mst_if.req.be    = m_be;
      #1;
      decode(m_add, tgt, err);
      can = (oq.size() < MAXT) && (oq.size() == 0 || (oq[$].tgt == tgt && oq[$].err == err));
      exp_sreq = '0;
      if (!m_rst && m_req && !err && can) exp_sreq[tgt] = 1'b1;
      exp_gnt = !m_rst && m_req && can && (err || (slv_gnt[tgt] == 1'b1));
      exp_rv = 1'b0; exp_rd = '0; exp_opc = 1'b0; exp_mask = '0;
      if (oq.size() > 0) begin
         if (oq[0].err) begin
            exp_rv = 1'b1; exp_rd = ERRD; exp_opc = 1'b1;
         end else begin
            exp_mask[oq[0].tgt] = 1'b1;
            exp_rv = slv_rv[oq[0].tgt];
            exp_rd = slv_rd[oq[0].tgt];
         end
      end
      if (m_rst) begin
         exp_rv = 1'b0; exp_rd = '0; exp_opc = 1'b0;
      end
      check_val("gnt", 32'(mst_if.rsp.gnt), 32'(exp_gnt));
      check_val("slv_req", 32'(slv_req), 32'(exp_sreq));
      check_val("r_valid", 32'(mst_if.rsp.r_valid), 32'(exp_rv));
      if (exp_rv || m_rst) begin
         check_val("r_rdata", mst_if.rsp.r_rdata, exp_rd);
         check_val("r_opc", 32'(mst_if.rsp.r_opc), 32'(exp_opc));
      end
      check_val("spurious", 32'(spurious), 32'(sp_exp));
      check_val("slv_add", slv_add, m_add);
      p_gnt    = exp_gnt;
      o_gnt    = mst_if.rsp.gnt;
      o_rv     = mst_if.rsp.r_valid;
      o_rd     = mst_if.rsp.r_rdata;
      o_opc    = mst_if.rsp.r_opc;
      o_sp     = spurious;
      o_sreq   = 32'(slv_req);
      step_cyc = cyc;
      // Advance the model to the next cycle.
      unexp  = slv_rv & ~exp_mask;
      sp_exp = m_rst ? 1'b0 : (sp_exp | (unexp != '0));
      for (int p = 0; p < NSLV; p++) begin
         if (slv_rv[p]) begin
            for (int k = 0; k < slave_q.size(); k++) begin
               if (slave_q[k].port == p) begin
                  slave_q.delete(k);
                  break;
               end
            end
         end
      end
      if (m_rst) begin
         oq.delete();
      end else begin
         if (exp_rv) void'(oq.pop_front());
         if (exp_gnt) begin
            ent_t e;
            e.tgt = tgt; e.err = err;
            oq.push_back(e);
            if (!err) begin
               sresp_t s;
               s.port = tgt;
               s.rdy  = cyc + $urandom_range(lat_max, lat_min);
               s.data = force_en ? force_data : $urandom();
               slave_q.push_back(s);
            end
         end
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      m_req = 1'b0;
      repeat (n) step();
   endtask

   task automatic send(input logic [31:0] a, input bit we);
      m_req = 1'b1; m_add = a; m_we = we; m_wdata = $urandom(); m_be = 4'($urandom());
      for (int i = 0; i < 40; i++) begin
         step();
         if (p_gnt) return;
      end
      check_val("send_gnt_timeout", 32'(o_gnt), 32'd1);
   endtask

   task automatic wait_rsp(output int unsigned rc);
      m_req = 1'b0;
      rc = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (o_rv) begin
            rc = step_cyc;
            return;
         end
      end
      check_val("rsp_timeout", 32'(o_rv), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned g, rc, c0, c5;
      int n, ng, nrv;
      logic [31:0] prev_add;
      mst_if.req = '0;
      m_rst = 1'b1;
      idle(2);
      m_rst = 1'b0;
      idle(2);

      // Timer read, fixed 2-cycle response
      gnt_pct = 100; lat_min = 2; lat_max = 2; force_en = 1'b1; force_data = 32'h1234;
      send(32'h1020_0404, 1'b0);
      check_val("t1_slv_req", o_sreq, 32'h2);
      check_val("t1_gnt", 32'(o_gnt), 32'd1);
      g = step_cyc;
      wait_rsp(rc);
      check_val("t1_latency", rc - g, 32'd2);
      check_val("t1_rdata", o_rd, 32'h1234);
      check_val("t1_opc", 32'(o_opc), 32'd0);
      force_en = 1'b0;

      // Slots 3 and 2 both reach the event unit
      send(32'h1020_0C00, 1'b1);
      check_val("t2_slot3", o_sreq, 32'h4);
      wait_rsp(rc);
      send(32'h1020_0800, 1'b0);
      check_val("t2_slot2", o_sreq, 32'h4);
      wait_rsp(rc);

      // Unmapped slot and out-of-region accesses
      send(32'h1020_3000, 1'b1);
      check_val("t3_unm_req", o_sreq, 32'h0);
      check_val("t3_unm_gnt", 32'(o_gnt), 32'd1);
      idle(1);
      check_val("t3_unm_rv", 32'(o_rv), 32'd1);
      check_val("t3_unm_opc", 32'(o_opc), 32'd1);
      check_val("t3_unm_rd", o_rd, 32'hBADA_CCE5);
      send(32'h1000_0000, 1'b0);
      check_val("t3_oor_req", o_sreq, 32'h0);
      idle(1);
      check_val("t3_oor_rv", 32'(o_rv), 32'd1);
      check_val("t3_oor_rd", o_rd, 32'hBADA_CCE5);
      idle(2);

      // Five back-to-back reads to port 6 with slow responses
      lat_min = 8; lat_max = 8;
      m_req = 1'b1; m_add = 32'h1020_1800; m_we = 1'b0;
      n = 0; ng = 0; c0 = 0; c5 = 0;
      for (int i = 0; i < 40 && n < 5; i++) begin
         step();
         if (i < 5) ng += int'(o_gnt);
         if (p_gnt) begin
            n++;
            if (n == 1) c0 = step_cyc;
            if (n == 5) c5 = step_cyc;
         end
      end
      check_val("t4_grants_first5", 32'(ng), 32'd4);
      check_val("t4_5th_delay", c5 - c0, 32'd9);
      idle(20);

      // Target switch waits for the previous target to drain
      lat_min = 6; lat_max = 6;
      send(32'h1020_0400, 1'b0);
      g = step_cyc;
      m_req = 1'b1; m_add = 32'h1020_1C00;
      step();
      check_val("t5_blocked", o_sreq, 32'h0);
      for (int i = 0; i < 30 && !p_gnt; i++) step();
      check_val("t5_switch_delay", step_cyc - g, 32'd7);
      check_val("t5_port7_req", o_sreq, 32'h80);
      idle(10);

      // Random traffic
      gnt_pct = 70; lat_min = 1; lat_max = 5;
      prev_add = 32'h1020_0000;
      for (int i = 0; i < 400; i++) begin
         if (!m_req || p_gnt) begin
            if ($urandom_range(99) < 70) begin
               int r;
               r = $urandom_range(99);
               if (r < 15) m_add = $urandom();
               else if (r < 55) m_add = prev_add;
               else m_add = 32'h1020_0000 | (32'($urandom_range(15)) << 10) | (32'($urandom_range(255)) << 2);
               prev_add = m_add;
               m_req = 1'b1; m_we = 1'($urandom()); m_wdata = $urandom(); m_be = 4'($urandom());
            end else begin
               m_req = 1'b0;
            end
         end
         step();
      end
      idle(20);

      // Reset with two transactions in flight; late responses become spurious
      gnt_pct = 100; lat_min = 8; lat_max = 8;
      send(32'h1020_1800, 1'b0);
      send(32'h1020_1800, 1'b0);
      m_rst = 1'b1;
      m_req = 1'b1;
      step();
      check_val("t6_rst_gnt", 32'(o_gnt), 32'd0);
      check_val("t6_rst_req", o_sreq, 32'h0);
      check_val("t6_rst_rv", 32'(o_rv), 32'd0);
      m_rst = 1'b0;
      m_req = 1'b0;
      nrv = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         nrv += int'(o_rv);
      end
      check_val("t6_no_rvalid", 32'(nrv), 32'd0);
      check_val("t6_spurious", 32'(o_sp), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
